fb_write_arbiter: RTL
=====================

FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 19, framebuffer word address width; DATA_W, default 24, pixel data width; MAX_BURST, default 16, beats per grant before forced release.
REQ-002 Ports SHALL be:
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- d_valid  in  1  draw requester beat valid
- d_last  in  1  draw beat ends burst
- d_addr  in  ADDR_W  draw write address
- d_data  in  DATA_W  draw write data
- d_grant  out  1  draw owns port
- d_ack  out  1  draw beat accepted
- f_valid  in  1  fill requester beat valid
- f_last  in  1  fill beat ends burst
- f_addr  in  ADDR_W  fill write address
- f_data  in  DATA_W  fill write data
- f_grant  out  1  fill owns port
- f_ack  out  1  fill beat accepted
- mem_ready  in  1  framebuffer port can take a write this cycle
- mem_wr  out  1  write strobe
- mem_addr  out  ADDR_W  write address
- mem_data  out  DATA_W  write data
- busy  out  1  a grant is active

Function
REQ-003 FSM states SHALL be IDLE, GRANT_D, GRANT_F; state, priority pointer (prio) and beat counter (cnt, width clog2(MAX_BURST)+1) SHALL be the only registers.
REQ-004 d_grant SHALL be 1 exactly in GRANT_D, f_grant exactly in GRANT_F, busy in either.
REQ-005 mem_wr SHALL equal (GRANT_D & d_valid) | (GRANT_F & f_valid), combinational.
REQ-006 mem_addr/mem_data SHALL mux the granted requester's addr/data; in IDLE they SHALL be 0.
REQ-007 Beat accept SHALL be mem_wr & mem_ready; d_ack/f_ack SHALL be accept qualified by the matching grant, combinational, same cycle.
REQ-008 Requesters SHALL hold valid/last/addr/data stable until ack; the arbiter SHALL NOT check this.
REQ-009 IDLE: if only one valid, next state SHALL grant it; if both valid, grant the one prio selects (prio=0 draw, prio=1 fill); if none, stay IDLE.
REQ-010 Arbitration latency SHALL be one cycle: valid seen in IDLE at edge N gives grant and possible mem_wr in cycle N+1.
REQ-011 cnt SHALL clear on entering any GRANT state and increment on every accepted beat.
REQ-012 Release SHALL occur on an accepted beat with last=1, or on the accepted beat that makes cnt equal MAX_BURST.
REQ-013 On release, prio SHALL point to the other requester; next state SHALL be the other GRANT state if the other valid is 1 that cycle, else IDLE (no dead cycle on handover).
REQ-014 Holder deasserting valid without last SHALL NOT release the grant (burst lock); mem_wr stays 0 until valid returns.
REQ-015 mem_ready=0 SHALL stall: no ack, cnt and state unchanged.
REQ-016 Forced release at MAX_BURST SHALL apply even if last=0; the requester re-competes from IDLE/handover with its remaining beats.
REQ-017 Non-granted requester's valid SHALL NOT affect mem_* outputs or its ack (ack=0).

Reset
REQ-018 n_rst low SHALL asynchronously force state IDLE, prio=0, cnt=0; hence d_grant, f_grant, d_ack, f_ack, mem_wr, busy=0 and mem_addr=mem_data=0.
REQ-019 Reset mid-burst SHALL abandon the burst with no further mem_wr; first grant after release follows REQ-009 with prio=0.

Verification
REQ-020 Single draw: d_valid=1, 3 beats addr 0x100..0x102, last on 3rd, mem_ready=1 -> d_grant cycle after valid, 3 consecutive mem_wr with matching addr/data, then IDLE, prio=1.
REQ-021 Contention from reset: d_valid,f_valid both 1, 2-beat bursts each -> draw first (prio=0), fill granted the cycle after draw's last beat, zero idle cycles, then prio=0.
REQ-022 Stall: fill granted, mem_ready low 4 cycles mid-burst -> mem_wr=1, f_ack=0, addr/data held, cnt unchanged; ack resumes when mem_ready=1.
REQ-023 Forced release: MAX_BURST=16, draw 20-beat burst, fill waiting -> exactly 16 draw beats, fill burst, then draw's remaining 4 beats.
REQ-024 Burst lock: draw drops d_valid 3 cycles mid-burst while f_valid=1 -> d_grant stays 1, mem_wr=0, f_ack=0 throughout.
REQ-025 Async reset in GRANT_F mid-burst -> all outputs 0 immediately without clock edge; after release with both valid, draw granted first.

Source files
------------

// File: rtl/fb_write_arbiter.sv
// -----------------------------------------------------------------------------
// fb_write_arbiter
//
// Two-requester write arbiter in front of a single framebuffer write port.
// A "draw" requester and a "fill" requester each present write beats; the
// arbiter grants one of them ownership of the port for a whole burst
// (terminated by *_last) or for at most MAX_BURST accepted beats, whichever
// comes first. Ownership then alternates when both requesters want the port.
//
// Handshake: a requester presents a beat by raising *_valid with *_addr,
// *_data and *_last, and keeps all four stable until it sees *_ack. A beat is
// accepted (and *_ack pulses in the same cycle) when its requester holds the
// grant, *_valid is high and mem_ready is high. mem_wr is the raw write strobe
// towards the framebuffer; the framebuffer takes the write only when mem_ready
// is also high.
//
// Ports:
//   clk, n_rst            clock, asynchronous active-low reset
//   d_valid/d_last/d_addr/d_data   draw beat in
//   d_grant/d_ack                  draw owns port / draw beat accepted
//   f_valid/f_last/f_addr/f_data   fill beat in
//   f_grant/f_ack                  fill owns port / fill beat accepted
//   mem_ready                      framebuffer can take a write this cycle
//   mem_wr/mem_addr/mem_data       framebuffer write strobe, address, data
//   busy                           some requester holds the grant
// -----------------------------------------------------------------------------
module fb_write_arbiter #(
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 24,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              d_valid,
    input  logic              d_last,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_data,
    output logic              d_grant,
    output logic              d_ack,
    input  logic              f_valid,
    input  logic              f_last,
    input  logic [ADDR_W-1:0] f_addr,
    input  logic [DATA_W-1:0] f_data,
    output logic              f_grant,
    output logic              f_ack,
    input  logic              mem_ready,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              busy
);

    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_D = 2'd1,
        GRANT_F = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               prio_q, prio_d;   // 0: draw wins a tie, 1: fill wins
    logic [CNT_W-1:0]   cnt_q, cnt_d;     // beats accepted in current grant

    logic               accept;
    logic               cur_last;
    logic [CNT_W-1:0]   cnt_inc;
    logic               rel;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath and outputs (all combinational on the current grant)
    // -------------------------------------------------------------------------
    always_comb begin
        d_grant  = (state_q == GRANT_D);
        f_grant  = (state_q == GRANT_F);
        busy     = d_grant | f_grant;

        // Only the holder's valid reaches the strobe; the other side is ignored.
        mem_wr   = (d_grant & d_valid) | (f_grant & f_valid);
        accept   = mem_wr & mem_ready;
        d_ack    = accept & d_grant;
        f_ack    = accept & f_grant;

        mem_addr = '0;
        mem_data = '0;
        cur_last = 1'b0;
        if (d_grant) begin
            mem_addr = d_addr;
            mem_data = d_data;
            cur_last = d_last;
        end else if (f_grant) begin
            mem_addr = f_addr;
            mem_data = f_data;
            cur_last = f_last;
        end

        cnt_inc  = cnt_q + CNT_W'(1);
        // Release on the accepted beat that ends the burst or that uses up
        // the beat budget; the holder keeps any leftover beats for later.
        rel      = accept & (cur_last | (cnt_inc == CNT_W'(MAX_BURST)));
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (d_valid && (!f_valid || !prio_q)) begin
                    state_d = GRANT_D;
                    cnt_d   = '0;
                end else if (f_valid) begin
                    state_d = GRANT_F;
                    cnt_d   = '0;
                end
            end

            GRANT_D: begin
                if (accept) begin
                    cnt_d = cnt_inc;
                end
                if (rel) begin
                    prio_d = 1'b1;
                    // Direct handover avoids a dead IDLE cycle.
                    if (f_valid) begin
                        state_d = GRANT_F;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            GRANT_F: begin
                if (accept) begin
                    cnt_d = cnt_inc;
                end
                if (rel) begin
                    prio_d = 1'b0;
                    if (d_valid) begin
                        state_d = GRANT_D;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
